// File: rtl/xadac_vhazard_if.sv
// xadac_if: four-channel decode/execute handshake bundle.
//   dec_req : valid/ready, id, instr          (master -> slave)
//   dec_rsp : valid/ready, id, accept, vd_clobber, vs_read (slave -> master)
//   exe_req : valid/ready, id, instr          (master -> slave)
//   exe_rsp : valid/ready, id, data           (slave -> master)
// Modport slv is the view of a block that receives requests.
// Modport mst is the view of a block that issues requests.
interface xadac_if #(
    parameter int IdW  = 3,
    parameter int NoVs = 3
);
    logic            dec_req_valid;
    logic            dec_req_ready;
    logic [IdW-1:0]  dec_req_id;
    logic [31:0]     dec_req_instr;

    logic            dec_rsp_valid;
    logic            dec_rsp_ready;
    logic [IdW-1:0]  dec_rsp_id;
    logic            dec_rsp_accept;
    logic            dec_rsp_vd_clobber;
    logic [NoVs-1:0] dec_rsp_vs_read;

    logic            exe_req_valid;
    logic            exe_req_ready;
    logic [IdW-1:0]  exe_req_id;
    logic [31:0]     exe_req_instr;

    logic            exe_rsp_valid;
    logic            exe_rsp_ready;
    logic [IdW-1:0]  exe_rsp_id;
    logic [31:0]     exe_rsp_data;

    modport slv (
        input  dec_req_valid, dec_req_id, dec_req_instr,
        output dec_req_ready,
        output dec_rsp_valid, dec_rsp_id, dec_rsp_accept, dec_rsp_vd_clobber, dec_rsp_vs_read,
        input  dec_rsp_ready,
        input  exe_req_valid, exe_req_id, exe_req_instr,
        output exe_req_ready,
        output exe_rsp_valid, exe_rsp_id, exe_rsp_data,
        input  exe_rsp_ready
    );

    modport mst (
        output dec_req_valid, dec_req_id, dec_req_instr,
        input  dec_req_ready,
        input  dec_rsp_valid, dec_rsp_id, dec_rsp_accept, dec_rsp_vd_clobber, dec_rsp_vs_read,
        output dec_rsp_ready,
        output exe_req_valid, exe_req_id, exe_req_instr,
        input  exe_req_ready,
        input  exe_rsp_valid, exe_rsp_id, exe_rsp_data,
        output exe_rsp_ready
    );
endinterface

// File: rtl/xadac_vhazard.sv
// xadac_vhazard: vector register hazard filter between an xadac slave port
// (upstream) and master port (downstream). Payloads pass straight through;
// only valid/ready are gated. Execute requests are held back on RAW, WAW
// (EnWaw) and WAR (EnWar) hazards and on reader-counter saturation.
//   clk, rstn   : clock, asynchronous active-low reset
//   slv, mst    : upstream / downstream xadac ports
//   flush_i     : drop all tracked state; blocks every handshake that cycle
//   busy_o      : per register, pending write or outstanding readers
//   idle_o      : nothing tracked at all
//   stall_o     : {WAR, WAW, RAW/saturation} for the current exe request
module xadac_vhazard #(
    parameter int NoVec = 32,
    parameter int NoVs  = 3,
    parameter int SbLen = 8,
    parameter int CntW  = 2,
    parameter bit EnWar = 1'b1,
    parameter bit EnWaw = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    xadac_if.slv             slv,
    xadac_if.mst             mst,
    input  logic             flush_i,
    output logic [NoVec-1:0] busy_o,
    output logic             idle_o,
    output logic [2:0]       stall_o
);
    localparam int AW     = 5;
    localparam int CntMax = (2 ** CntW) - 1;

    typedef struct packed {
        logic [AW-1:0]           vd_addr;
        logic                    vd_clobber;
        logic [NoVs-1:0]         vs_read;
        logic [NoVs-1:0][AW-1:0] vs_addr;
        logic                    dreq_done;
        logic                    drsp_done;
        logic                    ereq_done;
        logic                    ersp_done;
    } entry_t;

    entry_t           sb_q   [SbLen];
    entry_t           sb_d   [SbLen];
    logic [NoVec-1:0] pend_q, pend_d;
    logic [CntW-1:0]  cnt_q  [NoVec];
    logic [CntW-1:0]  cnt_d  [NoVec];

    entry_t e_dq, e_dr, e_xq, e_xr;
    logic [NoVs-1:0][AW-1:0] xq_vs;
    logic en, dq_go, dr_go, xq_go, xr_go;
    logic hs_dq, hs_dr, hs_xq, hs_xr;
    logic raw, sat, waw, war;
    logic cnt_underflow;

    function automatic logic [AW-1:0] vs_field(input logic [31:0] instr, input int i);
        case (i)
            0:       return instr[19:15];
            1:       return instr[24:20];
            default: return instr[11:7];
        endcase
    endfunction

    assign e_dq = sb_q[slv.dec_req_id];
    assign e_dr = sb_q[mst.dec_rsp_id];
    assign e_xq = sb_q[slv.exe_req_id];
    assign e_xr = sb_q[mst.exe_rsp_id];

    // Hazards look only at registered state: a release in this cycle is seen next cycle.
    always_comb begin : p_hazard
        int n;
        raw = 1'b0;
        sat = 1'b0;
        n   = 0;
        for (int i = 0; i < NoVs; i++) begin
            xq_vs[i] = vs_field(slv.exe_req_instr, i);
        end
        for (int i = 0; i < NoVs; i++) begin
            if (e_xq.vs_read[i]) begin
                if (pend_q[xq_vs[i]]) raw = 1'b1;
                // operands naming the same register all land on one counter
                n = 0;
                for (int j = 0; j < NoVs; j++) begin
                    if (e_xq.vs_read[j] && (xq_vs[j] == xq_vs[i])) n++;
                end
                if (int'(cnt_q[xq_vs[i]]) + n > CntMax) sat = 1'b1;
            end
        end
        waw = EnWaw && e_xq.vd_clobber && pend_q[e_xq.vd_addr];
        war = EnWar && e_xq.vd_clobber && (cnt_q[e_xq.vd_addr] != '0);
    end

    assign en    = rstn & ~flush_i;
    assign dq_go = en & ~e_dq.dreq_done;
    assign dr_go = en & ~e_dr.drsp_done;
    assign xq_go = en & e_xq.drsp_done & ~e_xq.ereq_done & ~(raw | sat | waw | war);
    assign xr_go = en & e_xr.ereq_done & ~e_xr.ersp_done;

    assign mst.dec_req_valid      = slv.dec_req_valid & dq_go;
    assign slv.dec_req_ready      = mst.dec_req_ready & dq_go;
    assign mst.dec_req_id         = slv.dec_req_id;
    assign mst.dec_req_instr      = slv.dec_req_instr;

    assign slv.dec_rsp_valid      = mst.dec_rsp_valid & dr_go;
    assign mst.dec_rsp_ready      = slv.dec_rsp_ready & dr_go;
    assign slv.dec_rsp_id         = mst.dec_rsp_id;
    assign slv.dec_rsp_accept     = mst.dec_rsp_accept;
    assign slv.dec_rsp_vd_clobber = mst.dec_rsp_vd_clobber;
    assign slv.dec_rsp_vs_read    = mst.dec_rsp_vs_read;

    assign mst.exe_req_valid      = slv.exe_req_valid & xq_go;
    assign slv.exe_req_ready      = mst.exe_req_ready & xq_go;
    assign mst.exe_req_id         = slv.exe_req_id;
    assign mst.exe_req_instr      = slv.exe_req_instr;

    assign slv.exe_rsp_valid      = mst.exe_rsp_valid & xr_go;
    assign mst.exe_rsp_ready      = slv.exe_rsp_ready & xr_go;
    assign slv.exe_rsp_id         = mst.exe_rsp_id;
    assign slv.exe_rsp_data       = mst.exe_rsp_data;

    assign hs_dq = slv.dec_req_valid & slv.dec_req_ready;
    assign hs_dr = mst.dec_rsp_valid & mst.dec_rsp_ready;
    assign hs_xq = slv.exe_req_valid & slv.exe_req_ready;
    assign hs_xr = mst.exe_rsp_valid & mst.exe_rsp_ready;

    assign stall_o = (slv.exe_req_valid && e_xq.drsp_done) ? {war, waw, raw | sat} : 3'b000;

    always_comb begin : p_next
        int inc;
        int dec;
        for (int k = 0; k < SbLen; k++) sb_d[k] = sb_q[k];
        pend_d        = pend_q;
        cnt_underflow = 1'b0;
        inc           = 0;
        dec           = 0;

        if (hs_dq) begin
            sb_d[slv.dec_req_id].vd_addr   = slv.dec_req_instr[11:7];
            sb_d[slv.dec_req_id].dreq_done = 1'b1;
        end
        if (hs_dr) begin
            if (mst.dec_rsp_accept) begin
                sb_d[mst.dec_rsp_id].vd_clobber = mst.dec_rsp_vd_clobber;
                sb_d[mst.dec_rsp_id].vs_read    = mst.dec_rsp_vs_read;
                sb_d[mst.dec_rsp_id].drsp_done  = 1'b1;
            end else begin
                sb_d[mst.dec_rsp_id] = '0;
            end
        end
        if (hs_xq) begin
            sb_d[slv.exe_req_id].vs_addr   = xq_vs;
            sb_d[slv.exe_req_id].ereq_done = 1'b1;
        end
        if (hs_xr) begin
            sb_d[mst.exe_rsp_id].ersp_done = 1'b1;
        end
        // a fully retired transaction frees its ID immediately
        for (int k = 0; k < SbLen; k++) begin
            if (sb_d[k].dreq_done && sb_d[k].drsp_done && sb_d[k].ereq_done && sb_d[k].ersp_done)
                sb_d[k] = '0;
        end

        // clear first so a same-cycle set on the same register wins
        if (hs_xr && e_xr.vd_clobber) pend_d[e_xr.vd_addr] = 1'b0;
        if (hs_xq && e_xq.vd_clobber) pend_d[e_xq.vd_addr] = 1'b1;

        for (int r = 0; r < NoVec; r++) begin
            inc = 0;
            dec = 0;
            for (int i = 0; i < NoVs; i++) begin
                if (hs_xq && e_xq.vs_read[i] && (xq_vs[i] == AW'(r))) inc++;
                if (hs_xr && e_xr.vs_read[i] && (e_xr.vs_addr[i] == AW'(r))) dec++;
            end
            if (int'(cnt_q[r]) + inc < dec) cnt_underflow = 1'b1;
            cnt_d[r] = CntW'(int'(cnt_q[r]) + inc - dec);
        end

        if (flush_i) begin
            for (int k = 0; k < SbLen; k++) sb_d[k] = '0;
            pend_d = '0;
            for (int r = 0; r < NoVec; r++) cnt_d[r] = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < SbLen; k++) sb_q[k] <= '0;
            pend_q <= '0;
            for (int r = 0; r < NoVec; r++) cnt_q[r] <= '0;
        end else begin
            for (int k = 0; k < SbLen; k++) sb_q[k] <= sb_d[k];
            pend_q <= pend_d;
            for (int r = 0; r < NoVec; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always @(posedge clk) begin
        if (rstn && !flush_i) assert (!cnt_underflow);
    end

    always_comb begin
        idle_o = ~|pend_q;
        for (int r = 0; r < NoVec; r++) begin
            busy_o[r] = pend_q[r] | (cnt_q[r] != '0);
            if (cnt_q[r] != '0) idle_o = 1'b0;
        end
        for (int k = 0; k < SbLen; k++) begin
            if (sb_q[k].dreq_done || sb_q[k].drsp_done || sb_q[k].ereq_done || sb_q[k].ersp_done)
                idle_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_xadac_vhazard.sv
// Directed bench for xadac_vhazard. Two instances share the same stimulus:
// g_dut[0] has WAR stalling enabled, g_dut[1] has it disabled.
module tb_xadac_vhazard;
    logic        clk = 1'b0;
    logic        rstn, flush;
    logic        dq_v, dr_v, xq_v, xr_v;
    logic [2:0]  dq_id, dr_id, xq_id, xr_id;
    logic [31:0] dq_in, xq_in;
    logic        dr_acc, dr_clb;
    logic [2:0]  dr_rd;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        xadac_if #(.IdW(3), .NoVs(3)) s_if ();
        xadac_if #(.IdW(3), .NoVs(3)) m_if ();
        logic [31:0] busy;
        logic        idle;
        logic [2:0]  stall;
        logic        dq_fwd, dq_rdy, dr_fwd, xq_fwd, xr_fwd;
        logic [31:0] pay;

        assign s_if.dec_req_valid      = dq_v;
        assign s_if.dec_req_id         = dq_id;
        assign s_if.dec_req_instr      = dq_in;
        assign m_if.dec_req_ready      = 1'b1;
        assign m_if.dec_rsp_valid      = dr_v;
        assign m_if.dec_rsp_id         = dr_id;
        assign m_if.dec_rsp_accept     = dr_acc;
        assign m_if.dec_rsp_vd_clobber = dr_clb;
        assign m_if.dec_rsp_vs_read    = dr_rd;
        assign s_if.dec_rsp_ready      = 1'b1;
        assign s_if.exe_req_valid      = xq_v;
        assign s_if.exe_req_id         = xq_id;
        assign s_if.exe_req_instr      = xq_in;
        assign m_if.exe_req_ready      = 1'b1;
        assign m_if.exe_rsp_valid      = xr_v;
        assign m_if.exe_rsp_id         = xr_id;
        assign m_if.exe_rsp_data       = {16'hD00D, 13'd0, xr_id};
        assign s_if.exe_rsp_ready      = 1'b1;

        assign dq_fwd = m_if.dec_req_valid;
        assign dq_rdy = s_if.dec_req_ready;
        assign dr_fwd = s_if.dec_rsp_valid;
        assign xq_fwd = m_if.exe_req_valid;
        assign xr_fwd = s_if.exe_rsp_valid;
        assign pay = m_if.dec_req_instr ^ m_if.exe_req_instr ^ s_if.exe_rsp_data ^
                     {15'd0, m_if.dec_req_id, s_if.dec_rsp_id, m_if.exe_req_id, s_if.exe_rsp_id,
                      s_if.dec_rsp_accept, s_if.dec_rsp_vd_clobber, s_if.dec_rsp_vs_read} ^
                     {31'd0, m_if.dec_rsp_ready ^ m_if.exe_rsp_ready ^ s_if.exe_req_ready};

        xadac_vhazard #(
            .NoVec(32), .NoVs(3), .SbLen(8), .CntW(2),
            .EnWar(g == 0 ? 1'b1 : 1'b0), .EnWaw(1'b1)
        ) u_dut (
            .clk     (clk),
            .rstn    (rstn),
            .slv     (s_if),
            .mst     (m_if),
            .flush_i (flush),
            .busy_o  (busy),
            .idle_o  (idle),
            .stall_o (stall)
        );
    end

    function automatic logic [31:0] mk(input logic [4:0] f2, input logic [4:0] vs0, input logic [4:0] vs1);
        return {7'd0, vs1, vs0, 3'd0, f2, 7'd0};
    endfunction

    // expected payload fold when no handshake readies are enabled by the DUT
    function automatic logic [31:0] pay_exp();
        return dq_in ^ xq_in ^ {16'hD00D, 13'd0, xr_id} ^
               {15'd0, dq_id, dr_id, xq_id, xr_id, dr_acc, dr_clb, dr_rd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [2:0] id, input logic [31:0] ins, input logic clb, input logic [2:0] rd);
        dq_v = 1'b1; dq_id = id; dq_in = ins;
        cyc();
        dq_v = 1'b0;
        dr_v = 1'b1; dr_id = id; dr_acc = 1'b1; dr_clb = clb; dr_rd = rd;
        cyc();
        dr_v = 1'b0;
    endtask

    task automatic xreq(input logic [2:0] id, input logic [31:0] ins);
        xq_v = 1'b1; xq_id = id; xq_in = ins;
        #1;
    endtask

    task automatic xrsp(input logic [2:0] id);
        xr_v = 1'b1; xr_id = id;
        cyc();
        xr_v = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0;
        dq_v = 1'b1; dq_id = 3'd0; dq_in = 32'h1234_5678;
        dr_v = 1'b0; dr_id = 3'd0; dr_acc = 1'b0; dr_clb = 1'b0; dr_rd = 3'd0;
        xq_v = 1'b1; xq_id = 3'd0; xq_in = '0;
        xr_v = 1'b0; xr_id = 3'd0;
        cyc();
        cyc();
        chk("rst_busy",   g_dut[0].busy, 32'd0);
        chk("rst_idle",   32'(g_dut[0].idle), 32'd1);
        chk("rst_stall",  32'(g_dut[0].stall), 32'd0);
        chk("rst_dq_fwd", 32'(g_dut[0].dq_fwd), 32'd0);
        chk("rst_dq_rdy", 32'(g_dut[0].dq_rdy), 32'd0);
        chk("rst_xq_fwd", 32'(g_dut[0].xq_fwd), 32'd0);
        chk("rst_pay",    g_dut[0].pay, pay_exp());
        dq_v = 1'b0; xq_v = 1'b0;
        rstn = 1'b1;
        cyc();

        // RAW on v4
        dec(3'd0, mk(5'd4, 5'd0, 5'd0), 1'b1, 3'b000);
        dec(3'd1, mk(5'd10, 5'd4, 5'd0), 1'b1, 3'b001);
        xreq(3'd0, mk(5'd4, 5'd0, 5'd0));
        chk("raw_id0_fwd", 32'(g_dut[0].xq_fwd), 32'd1);
        cyc();
        xreq(3'd1, mk(5'd10, 5'd4, 5'd0));
        chk("raw_stall",   32'(g_dut[0].stall), 32'd1);
        chk("raw_held",    32'(g_dut[0].xq_fwd), 32'd0);
        chk("raw_busy4",   32'(g_dut[0].busy[4]), 32'd1);
        cyc();
        chk("raw_stall2",  32'(g_dut[0].stall), 32'd1);
        xr_v = 1'b1; xr_id = 3'd0;
        #1;
        chk("raw_rsp_fwd", 32'(g_dut[0].xr_fwd), 32'd1);
        chk("raw_nobyp",   32'(g_dut[0].stall), 32'd1);
        cyc();
        xr_v = 1'b0;
        #1;
        chk("raw_release", 32'(g_dut[0].stall), 32'd0);
        chk("raw_id1_fwd", 32'(g_dut[0].xq_fwd), 32'd1);
        cyc();
        xq_v = 1'b0;
        xrsp(3'd1);
        chk("raw_idle", 32'(g_dut[0].idle), 32'd1);
        chk("raw_busy", g_dut[0].busy, 32'd0);

        // WAR on v5, with and without WAR stalling
        dec(3'd0, mk(5'd0, 5'd5, 5'd0), 1'b0, 3'b001);
        dec(3'd1, mk(5'd5, 5'd0, 5'd0), 1'b1, 3'b000);
        xreq(3'd0, mk(5'd0, 5'd5, 5'd0));
        chk("war_rd_fwd", 32'(g_dut[0].xq_fwd), 32'd1);
        cyc();
        xreq(3'd1, mk(5'd5, 5'd0, 5'd0));
        chk("war_stall",     32'(g_dut[0].stall), 32'd4);
        chk("war_held",      32'(g_dut[0].xq_fwd), 32'd0);
        chk("nowar_stall",   32'(g_dut[1].stall), 32'd0);
        chk("nowar_fwd",     32'(g_dut[1].xq_fwd), 32'd1);
        cyc();
        chk("war_stall2",    32'(g_dut[0].stall), 32'd4);
        xr_v = 1'b1; xr_id = 3'd0;
        #1;
        chk("war_nobyp",     32'(g_dut[0].stall), 32'd4);
        cyc();
        xr_v = 1'b0;
        #1;
        chk("war_release",   32'(g_dut[0].xq_fwd), 32'd1);
        cyc();
        xq_v = 1'b0;
        xrsp(3'd1);
        chk("war_idle",   32'(g_dut[0].idle), 32'd1);
        chk("nowar_idle", 32'(g_dut[1].idle), 32'd1);

        // reader counter saturation on v7
        for (int id = 0; id < 4; id++) dec(3'(id), mk(5'd0, 5'd7, 5'd0), 1'b0, 3'b001);
        for (int id = 0; id < 3; id++) begin
            xreq(3'(id), mk(5'd0, 5'd7, 5'd0));
            chk("sat_issue", 32'(g_dut[0].xq_fwd), 32'd1);
            cyc();
        end
        xreq(3'd3, mk(5'd0, 5'd7, 5'd0));
        chk("sat_stall", 32'(g_dut[0].stall), 32'd1);
        chk("sat_held",  32'(g_dut[0].xq_fwd), 32'd0);
        chk("sat_busy7", 32'(g_dut[0].busy[7]), 32'd1);
        xr_v = 1'b1; xr_id = 3'd0;
        #1;
        chk("sat_nobyp", 32'(g_dut[0].stall), 32'd1);
        cyc();
        xr_v = 1'b0;
        #1;
        chk("sat_release", 32'(g_dut[0].xq_fwd), 32'd1);
        cyc();
        xq_v = 1'b0;
        for (int id = 1; id < 4; id++) xrsp(3'(id));
        chk("sat_idle", 32'(g_dut[0].idle), 32'd1);

        // duplicate operands on v9 count twice
        dec(3'd2, mk(5'd0, 5'd9, 5'd9), 1'b0, 3'b011);
        dec(3'd4, mk(5'd0, 5'd9, 5'd9), 1'b0, 3'b011);
        xreq(3'd2, mk(5'd0, 5'd9, 5'd9));
        chk("dup_issue", 32'(g_dut[0].xq_fwd), 32'd1);
        cyc();
        xreq(3'd4, mk(5'd0, 5'd9, 5'd9));
        chk("dup_sat",   32'(g_dut[0].stall), 32'd1);
        chk("dup_busy9", 32'(g_dut[0].busy[9]), 32'd1);
        xq_v = 1'b0;
        xrsp(3'd2);
        chk("dup_free9", 32'(g_dut[0].busy[9]), 32'd0);
        xreq(3'd4, mk(5'd0, 5'd9, 5'd9));
        chk("dup_reissue", 32'(g_dut[0].xq_fwd), 32'd1);
        cyc();
        xq_v = 1'b0;
        xrsp(3'd4);
        chk("dup_idle", 32'(g_dut[0].idle), 32'd1);

        // dec_rsp reject frees the ID
        dq_v = 1'b1; dq_id = 3'd3; dq_in = mk(5'd6, 5'd0, 5'd0);
        #1;
        chk("rej_dq_fwd", 32'(g_dut[0].dq_fwd), 32'd1);
        cyc();
        chk("rej_dq_blk", 32'(g_dut[0].dq_fwd), 32'd0);
        chk("rej_busy_id", 32'(g_dut[0].idle), 32'd0);
        dq_v = 1'b0;
        dr_v = 1'b1; dr_id = 3'd3; dr_acc = 1'b0; dr_clb = 1'b1; dr_rd = 3'b101;
        xr_id = 3'd6;
        #1;
        chk("rej_dr_fwd", 32'(g_dut[0].dr_fwd), 32'd1);
        chk("rej_pay",    g_dut[0].pay, pay_exp() ^ 32'd1);
        cyc();
        dr_v = 1'b0;
        dq_v = 1'b1;
        #1;
        chk("rej_dq_again", 32'(g_dut[0].dq_fwd), 32'd1);
        chk("rej_dq_rdy",   32'(g_dut[0].dq_rdy), 32'd1);
        cyc();
        dq_v = 1'b0;
        xr_v = 1'b1; xr_id = 3'd3;
        #1;
        chk("rej_xr_gate", 32'(g_dut[0].xr_fwd), 32'd0);
        xr_v = 1'b0;
        dr_v = 1'b1;
        cyc();
        dr_v = 1'b0;
        chk("rej_idle", 32'(g_dut[0].idle), 32'd1);

        // flush with two writers and a reader outstanding
        dec(3'd0, mk(5'd1, 5'd0, 5'd0), 1'b1, 3'b000);
        dec(3'd1, mk(5'd2, 5'd0, 5'd0), 1'b1, 3'b000);
        dec(3'd2, mk(5'd0, 5'd3, 5'd0), 1'b0, 3'b001);
        xreq(3'd0, mk(5'd1, 5'd0, 5'd0));
        cyc();
        xreq(3'd1, mk(5'd2, 5'd0, 5'd0));
        cyc();
        xreq(3'd2, mk(5'd0, 5'd3, 5'd0));
        cyc();
        xq_v = 1'b0;
        chk("fl_busy_pre", g_dut[0].busy, 32'h0000_000E);
        chk("fl_idle_pre", 32'(g_dut[0].idle), 32'd0);
        flush = 1'b1;
        dq_v = 1'b1; dq_id = 3'd5;
        xr_v = 1'b1; xr_id = 3'd0;
        #1;
        chk("fl_dq_rdy", 32'(g_dut[0].dq_rdy), 32'd0);
        chk("fl_dq_fwd", 32'(g_dut[0].dq_fwd), 32'd0);
        chk("fl_xr_fwd", 32'(g_dut[0].xr_fwd), 32'd0);
        cyc();
        flush = 1'b0; dq_v = 1'b0; xr_v = 1'b0;
        #1;
        chk("fl_busy", g_dut[0].busy, 32'd0);
        chk("fl_idle", 32'(g_dut[0].idle), 32'd1);
        dec(3'd5, mk(5'd0, 5'd1, 5'd0), 1'b0, 3'b001);
        xreq(3'd5, mk(5'd0, 5'd1, 5'd0));
        chk("fl_new_fwd",   32'(g_dut[0].xq_fwd), 32'd1);
        chk("fl_new_stall", 32'(g_dut[0].stall), 32'd0);
        cyc();
        xq_v = 1'b0;
        xrsp(3'd5);
        chk("fl_end_idle", 32'(g_dut[0].idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
